// File: rtl/beat_packer.sv
// rtl/beat_packer.sv - packs N L-bit valid/ready beats into one N*L-bit word with keep mask and packet-end flag
// Optional BEAT_PACKER_STATS_EN adds word_cnt/flush_cnt delivery counters.
module beat_packer #(
  parameter int L = 8,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  output logic           ready_f,
  input  logic           valid_f,
  input  logic [L-1:0]   data_f,
  input  logic           last_f,
  input  logic           ready_b,
  output logic           valid_b,
  output logic [N*L-1:0] data_b,
  output logic [N-1:0]   keep_b,
`ifdef BEAT_PACKER_STATS_EN
  output logic [15:0]    word_cnt,
  output logic [15:0]    flush_cnt,
`endif
  output logic           last_b
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {FILL, PEND} state_t;

  state_t         state, state_nx;
  logic [N*L-1:0] acc, acc_nx;
  logic [N-1:0]   acc_keep, keep_nx;
  logic [CW-1:0]  cnt;
  logic           pend_last;
  logic           take, complete, out_free, load_out, to_pend;

  always_comb begin
    state_nx = state;
    ready_f  = (state == FILL);
    take     = valid_f && ready_f;
    acc_nx   = acc;
    keep_nx  = acc_keep;
    for (int k = 0; k < N; k++) begin
      if (cnt == CW'(k)) begin
        acc_nx[k*L +: L] = data_f;
        keep_nx[k]       = 1'b1;
      end
    end
    complete = take && ((cnt == CW'(N - 1)) || last_f);
    out_free = !valid_b || ready_b;
    load_out = 1'b0;
    to_pend  = 1'b0;
    case (state)
      FILL: begin
        if (complete) begin
          if (out_free) begin
            load_out = 1'b1;
          end else begin
            to_pend  = 1'b1;
            state_nx = PEND;
          end
        end
      end
      PEND: begin
        if (ready_b) begin
          load_out = 1'b1;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_b   <= 1'b0;
      data_b    <= '0;
      keep_b    <= '0;
      last_b    <= 1'b0;
      acc       <= '0;
      acc_keep  <= '0;
      cnt       <= '0;
      pend_last <= 1'b0;
    end else begin
      if (load_out) begin
        valid_b <= 1'b1;
        // A pending word already sits in acc; a direct completion uses the merged beat.
        if (state == PEND) begin
          data_b <= acc;
          keep_b <= acc_keep;
          last_b <= pend_last;
        end else begin
          data_b <= acc_nx;
          keep_b <= keep_nx;
          last_b <= last_f;
        end
      end else if (valid_b && ready_b) begin
        valid_b <= 1'b0;
      end

      if (load_out) begin
        acc       <= '0;
        acc_keep  <= '0;
        cnt       <= '0;
        pend_last <= 1'b0;
      end else if (to_pend) begin
        acc       <= acc_nx;
        acc_keep  <= keep_nx;
        cnt       <= '0;
        pend_last <= last_f;
      end else if (take) begin
        acc       <= acc_nx;
        acc_keep  <= keep_nx;
        cnt       <= cnt + CW'(1);
      end
    end
  end

`ifdef BEAT_PACKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= '0;
      flush_cnt <= '0;
    end else if (valid_b && ready_b) begin
      word_cnt <= word_cnt + 16'd1;
      if (keep_b != {N{1'b1}}) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_beat_packer.sv
// tb/tb_beat_packer.sv - scoreboard bench for beat_packer (L=8, N=4)
module tb_beat_packer;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready_f;
  logic        valid_f = 1'b0;
  logic [7:0]  data_f = '0;
  logic        last_f = 1'b0;
  logic        ready_b = 1'b0;
  logic        valid_b;
  logic [31:0] data_b;
  logic [3:0]  keep_b;
  logic        last_b;
`ifdef BEAT_PACKER_STATS_EN
  logic [15:0] word_cnt, flush_cnt;
`endif

  int    checks = 0;
  int    errors = 0;
  int    delivered = 0;
  int    flushed = 0;
  bit    rb_rand = 1'b0;
  bit    hold_v = 1'b0;
  word_t held;
  word_t exp_q[$];

  beat_packer #(.L(8), .N(4)) dut (
    .clk(clk), .rst(rst),
    .ready_f(ready_f), .valid_f(valid_f), .data_f(data_f), .last_f(last_f),
    .ready_b(ready_b), .valid_b(valid_b), .data_b(data_b), .keep_b(keep_b),
`ifdef BEAT_PACKER_STATS_EN
    .word_cnt(word_cnt), .flush_cnt(flush_cnt),
`endif
    .last_b(last_b)
  );

  always #5 clk = ~clk;

  // Monitor: pops and compares on every output handshake, checks hold stability.
  initial begin
    word_t got, exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        got = '{d: data_b, k: keep_b, l: last_b};
        if (hold_v && valid_b) begin
          checks++;
          if (got != held) begin
            errors++;
            $display("FAIL hold_stable got=%h/%b/%b want=%h/%b/%b", got.d, got.k, got.l, held.d, held.k, held.l);
          end
        end
        if (valid_b && ready_b) begin
          checks++;
          delivered++;
          if (keep_b != 4'hf) flushed++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got=%h/%b/%b want=none", got.d, got.k, got.l);
          end else begin
            exp = exp_q.pop_front();
            if (got != exp) begin
              errors++;
              $display("FAIL word got=%h/%b/%b want=%h/%b/%b", got.d, got.k, got.l, exp.d, exp.k, exp.l);
            end
          end
        end
        hold_v = valid_b && !ready_b;
        held   = got;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rb_rand) ready_b = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back('{d: d, k: k, l: l});
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    int n = 0;
    bit done = 1'b0;
    valid_f = 1'b1;
    data_f  = d;
    last_f  = l;
    while (!done) begin
      @(negedge clk);
      if (ready_f) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout beat=%h accepted=0 want=1", d);
        done = 1'b1;
      end
    end
    valid_f = 1'b0;
    last_f  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      cyc(1);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_valid_b", {31'd0, valid_b}, 32'd0);
    chk("rst_keep_b", {28'd0, keep_b}, 32'd0);
    chk("rst_data_b", data_b, 32'd0);
    chk("rst_last_b", {31'd0, last_b}, 32'd0);
    chk("rst_ready_f", {31'd0, ready_f}, 32'd1);
  endtask

  initial begin
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    int          m_cnt;
    logic [7:0]  d;
    logic        l;

    cyc(3);
    do_reset();

    // Full word with ready_b high; visible one cycle after the fourth beat.
    ready_b = 1'b1;
    push_exp(32'h44332211, 4'b1111, 1'b0);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b0);
    chk("latency_valid_b", {31'd0, valid_b}, 32'd1);
    chk("latency_data_b", data_b, 32'h44332211);

    // Early flush by last_f.
    push_exp(32'h0000A2A1, 4'b0011, 1'b1);
    send_beat(8'hA1, 1'b0);
    send_beat(8'hA2, 1'b1);
    wait_drain();

    // Single-beat packet.
    push_exp(32'h000000B7, 4'b0001, 1'b1);
    send_beat(8'hB7, 1'b1);
    wait_drain();

    // Back-pressure: second word parks in PEND.
    ready_b = 1'b0;
    push_exp(32'h04030201, 4'b1111, 1'b0);
    push_exp(32'h08070605, 4'b1111, 1'b0);
    for (int i = 1; i <= 8; i++) send_beat(8'(i), 1'b0);
    chk("pend_ready_f", {31'd0, ready_f}, 32'd0);
    cyc(3);
    chk("pend_ready_f_hold", {31'd0, ready_f}, 32'd0);
    chk("pend_valid_b", {31'd0, valid_b}, 32'd1);
    ready_b = 1'b1;
    wait_drain();
    cyc(2);
    chk("idle_valid_b", {31'd0, valid_b}, 32'd0);

    // Reset mid-word, then a clean word.
    ready_b = 1'b0;
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    do_reset();
    ready_b = 1'b1;
    push_exp(32'h0D0C0B0A, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(8'(8'h0A + i), 1'b0);
    wait_drain();

    // Reset while in PEND, then a clean word.
    ready_b = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(8'(8'h21 + i), 1'b0);
    chk("pend2_ready_f", {31'd0, ready_f}, 32'd0);
    do_reset();
    ready_b = 1'b1;
    push_exp(32'h34333231, 4'b1111, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(8'(8'h31 + i), 1'b0);
    wait_drain();

    // Random traffic against a reference packer.
    m_data = '0;
    m_keep = '0;
    m_cnt  = 0;
    rb_rand = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      while ($urandom_range(0, 1) == 0) begin
        last_f = 1'($urandom_range(0, 1));
        cyc(1);
      end
      d = 8'($urandom);
      l = ($urandom_range(0, 3) == 0) || (b == 999);
      m_data[m_cnt*8 +: 8] = d;
      m_keep[m_cnt] = 1'b1;
      if (m_cnt == 3 || l) begin
        push_exp(m_data, m_keep, l);
        m_data = '0;
        m_keep = '0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
      send_beat(d, l);
    end
    rb_rand = 1'b0;
    ready_b = 1'b1;
    wait_drain();
    cyc(2);

`ifdef BEAT_PACKER_STATS_EN
    chk("word_cnt", {16'd0, word_cnt}, 32'(delivered % 65536));
    chk("flush_cnt", {16'd0, flush_cnt}, 32'(flushed % 65536));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached=1 want=0");
    $fatal(1, "timeout");
  end

endmodule
